// File: rtl/pipeif_fetchq.sv
// Instruction-fetch stage: fetch PC register, next-PC select and a DEPTH-entry
// queue of {pc, instruction} pairs that decouples IF from ID.
module pipeif_fetchq #(
    parameter int unsigned      WIDTH    = 32,
    parameter int unsigned      DEPTH    = 4,
    parameter logic [WIDTH-1:0] RESET_PC = '0
) (
    input  logic                     clock,
    input  logic                     resetn,
    input  logic [1:0]               pcsource,
    input  logic [WIDTH-1:0]         bpc,
    input  logic [WIDTH-1:0]         rpc,
    input  logic [WIDTH-1:0]         jpc,
    output logic [WIDTH-1:0]         imem_addr,
    input  logic [WIDTH-1:0]         imem_rdata,
    input  logic                     dec_ready,
    output logic                     dec_valid,
    output logic [WIDTH-1:0]         inst,
    output logic [WIDTH-1:0]         inst_pc,
    output logic [WIDTH-1:0]         pc4,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    typedef enum logic [1:0] {
        PC_SEQ    = 2'b00,
        PC_BRANCH = 2'b01,
        PC_REG    = 2'b10,
        PC_JUMP   = 2'b11
    } pcsel_e;

    pcsel_e           w_sel;
    logic [WIDTH-1:0] r_pc;
    logic [WIDTH-1:0] w_pc_plus4;
    logic [WIDTH-1:0] w_pc_next;
    logic [WIDTH-1:0] r_q_inst [DEPTH];
    logic [WIDTH-1:0] r_q_pc   [DEPTH];
    logic [AW-1:0]    r_head;
    logic [AW-1:0]    r_tail;
    logic [CW-1:0]    r_count;
    logic             w_redirect;
    logic             w_full;
    logic             w_pop;
    logic             w_push;

    assign w_sel      = pcsel_e'(pcsource);
    assign w_redirect = (w_sel != PC_SEQ);
    assign w_full     = (r_count == CW'(DEPTH));
    assign w_pop      = dec_valid & dec_ready;
    // A pop frees the slot the push writes into, so full+pop still fetches.
    assign w_push     = ~w_redirect & (~w_full | w_pop);
    assign w_pc_plus4 = r_pc + WIDTH'(4);

    always_comb begin
        w_pc_next = r_pc;
        unique case (w_sel)
            PC_BRANCH: w_pc_next = bpc;
            PC_REG:    w_pc_next = rpc;
            PC_JUMP:   w_pc_next = jpc;
            default: begin
                if (w_push) begin
                    w_pc_next = w_pc_plus4;
                end
            end
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_pc    <= RESET_PC;
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            r_pc <= w_pc_next;
            if (w_redirect) begin
                r_head  <= '0;
                r_tail  <= '0;
                r_count <= '0;
            end else begin
                if (w_push) begin
                    r_tail <= r_tail + AW'(1);
                end
                if (w_pop) begin
                    r_head <= r_head + AW'(1);
                end
                if (w_push && !w_pop) begin
                    r_count <= r_count + CW'(1);
                end else if (w_pop && !w_push) begin
                    r_count <= r_count - CW'(1);
                end
            end
        end
    end

    // Entry storage needs no reset: the head is masked while the queue is empty.
    always_ff @(posedge clock) begin
        if (w_push) begin
            r_q_inst[r_tail] <= imem_rdata;
            r_q_pc[r_tail]   <= r_pc;
        end
    end

    assign imem_addr = r_pc;
    assign count     = r_count;
    assign dec_valid = (r_count != '0);
    assign inst      = dec_valid ? r_q_inst[r_head] : '0;
    assign inst_pc   = dec_valid ? r_q_pc[r_head] : '0;
    assign pc4       = dec_valid ? (r_q_pc[r_head] + WIDTH'(4)) : '0;

endmodule

// File: tb/tb_pipeif_fetchq.sv
// Scoreboard bench for pipeif_fetchq: expected {pc, inst} pushed on modelled
// fetches, popped and compared whenever the decode side consumes the head.
module tb_pipeif_fetchq;

    localparam int unsigned DEPTH = 4;
    localparam logic [31:0] XKEY  = 32'hA5A5A5A5;
    localparam logic [31:0] WPC   = 32'hFFFFFFF8;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] ins;
    } ent_t;

    logic        clock;
    logic        resetn;
    logic [1:0]  pcsource;
    logic [31:0] bpc, rpc, jpc;
    logic        dec_ready;

    logic [31:0] imem_addr, imem_rdata, inst, inst_pc, pc4;
    logic        dec_valid;
    logic [2:0]  count;

    logic [31:0] w_imem_addr, w_imem_rdata, w_inst, w_inst_pc, w_pc4;
    logic        w_dec_valid;
    logic [2:0]  w_count;

    int unsigned n_pass;
    int unsigned n_total;
    logic [31:0] m_pc;
    ent_t        exp_q[$];

    assign imem_rdata   = imem_addr ^ XKEY;
    assign w_imem_rdata = w_imem_addr ^ XKEY;

    pipeif_fetchq #(.WIDTH(32), .DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
        .clock(clock), .resetn(resetn), .pcsource(pcsource),
        .bpc(bpc), .rpc(rpc), .jpc(jpc),
        .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .dec_ready(dec_ready), .dec_valid(dec_valid),
        .inst(inst), .inst_pc(inst_pc), .pc4(pc4), .count(count)
    );

    pipeif_fetchq #(.WIDTH(32), .DEPTH(DEPTH), .RESET_PC(WPC)) dut_w (
        .clock(clock), .resetn(resetn), .pcsource(pcsource),
        .bpc(bpc), .rpc(rpc), .jpc(jpc),
        .imem_addr(w_imem_addr), .imem_rdata(w_imem_rdata),
        .dec_ready(dec_ready), .dec_valid(w_dec_valid),
        .inst(w_inst), .inst_pc(w_inst_pc), .pc4(w_pc4), .count(w_count)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Scoreboard step: compare state and any consumed head, update the model,
    // then advance one clock and return at the following falling edge.
    task automatic sb_cycle();
        logic pop;
        ent_t e;
        pop = (exp_q.size() != 0) && dec_ready;
        n_total++;
        if (dec_valid !== (exp_q.size() != 0) || count !== 3'(exp_q.size()) || imem_addr !== m_pc)
            $display("FAIL sb_state: got valid=%b count=%0d addr=%h, expected valid=%b count=%0d addr=%h",
                     dec_valid, count, imem_addr, exp_q.size() != 0, exp_q.size(), m_pc);
        else n_pass++;
        if (pop) begin
            n_total++;
            if (inst_pc !== exp_q[0].pc || inst !== exp_q[0].ins || pc4 !== exp_q[0].pc + 32'd4)
                $display("FAIL sb_head: got pc=%h inst=%h pc4=%h, expected pc=%h inst=%h pc4=%h",
                         inst_pc, inst, pc4, exp_q[0].pc, exp_q[0].ins, exp_q[0].pc + 32'd4);
            else n_pass++;
            void'(exp_q.pop_front());
        end
        case (pcsource)
            2'b01: begin exp_q.delete(); m_pc = bpc; end
            2'b10: begin exp_q.delete(); m_pc = rpc; end
            2'b11: begin exp_q.delete(); m_pc = jpc; end
            default: begin
                if (exp_q.size() < DEPTH) begin
                    e.pc  = m_pc;
                    e.ins = m_pc ^ XKEY;
                    exp_q.push_back(e);
                    m_pc = m_pc + 32'd4;
                end
            end
        endcase
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic apply_reset();
        resetn = 1'b0;
        pcsource = 2'b00;
        dec_ready = 1'b0;
        exp_q.delete();
        m_pc = 32'h0;
        @(negedge clock);
        @(negedge clock);
        resetn = 1'b1;
    endtask

    task automatic test_reset();
        apply_reset();
        n_total++;
        if (dec_valid !== 1'b0 || count !== 3'd0 || inst !== 32'h0 || inst_pc !== 32'h0 ||
            pc4 !== 32'h0 || imem_addr !== 32'h0 || w_imem_addr !== WPC)
            $display("FAIL reset_state: got valid=%b count=%0d inst=%h pc=%h pc4=%h addr=%h waddr=%h",
                     dec_valid, count, inst, inst_pc, pc4, imem_addr, w_imem_addr);
        else n_pass++;
        dec_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            sb_cycle();
            n_total++;
            if (dec_valid !== 1'b1 || count !== 3'd1 || inst_pc !== 32'(4 * i) || pc4 !== 32'(4 * i + 4))
                $display("FAIL seq_stream[%0d]: got valid=%b count=%0d pc=%h pc4=%h, expected 1/1/%h/%h",
                         i, dec_valid, count, inst_pc, pc4, 32'(4 * i), 32'(4 * i + 4));
            else n_pass++;
        end
    endtask

    task automatic test_stall();
        logic [2:0] exp_cnt;
        apply_reset();
        for (int i = 0; i < 6; i++) begin
            sb_cycle();
            exp_cnt = (i < 3) ? 3'(i + 1) : 3'd4;
            n_total++;
            if (count !== exp_cnt || inst_pc !== 32'h0 || inst !== XKEY)
                $display("FAIL stall_fill[%0d]: got count=%0d pc=%h inst=%h, expected %0d/0/%h",
                         i, count, inst_pc, inst, exp_cnt, XKEY);
            else n_pass++;
        end
        n_total++;
        if (imem_addr !== 32'h10) $display("FAIL stall_addr: got %h expected 00000010", imem_addr);
        else n_pass++;
        dec_ready = 1'b1;
        sb_cycle();
        dec_ready = 1'b0;
        n_total++;
        if (count !== 3'd4 || imem_addr !== 32'h14 || inst_pc !== 32'h4)
            $display("FAIL full_pop_push: got count=%0d addr=%h pc=%h, expected 4/00000014/00000004",
                     count, imem_addr, inst_pc);
        else n_pass++;
    endtask

    task automatic test_branch();
        apply_reset();
        for (int i = 0; i < 3; i++) sb_cycle();
        pcsource = 2'b01;
        bpc = 32'h400;
        dec_ready = 1'b1;
        sb_cycle();
        pcsource = 2'b00;
        n_total++;
        if (count !== 3'd0 || dec_valid !== 1'b0 || imem_addr !== 32'h400)
            $display("FAIL branch_flush: got count=%0d valid=%b addr=%h, expected 0/0/00000400",
                     count, dec_valid, imem_addr);
        else n_pass++;
        sb_cycle();
        n_total++;
        if (dec_valid !== 1'b1 || inst_pc !== 32'h400 || inst !== (32'h400 ^ XKEY))
            $display("FAIL branch_target: got valid=%b pc=%h inst=%h, expected 1/00000400/%h",
                     dec_valid, inst_pc, inst, 32'h400 ^ XKEY);
        else n_pass++;
        for (int i = 0; i < 3; i++) sb_cycle();
    endtask

    task automatic test_back_to_back();
        dec_ready = 1'b1;
        pcsource = 2'b10;
        rpc = 32'h80;
        sb_cycle();
        pcsource = 2'b11;
        jpc = 32'h200;
        sb_cycle();
        pcsource = 2'b00;
        n_total++;
        if (dec_valid !== 1'b0 || imem_addr !== 32'h200)
            $display("FAIL b2b_flush: got valid=%b addr=%h, expected 0/00000200", dec_valid, imem_addr);
        else n_pass++;
        sb_cycle();
        n_total++;
        if (dec_valid !== 1'b1 || inst_pc !== 32'h200)
            $display("FAIL b2b_first: got valid=%b pc=%h, expected 1/00000200", dec_valid, inst_pc);
        else n_pass++;
        for (int i = 0; i < 3; i++) sb_cycle();
    endtask

    task automatic test_wrap();
        logic [31:0] exp_pc [3];
        exp_pc[0] = 32'hFFFFFFF8;
        exp_pc[1] = 32'hFFFFFFFC;
        exp_pc[2] = 32'h0;
        apply_reset();
        dec_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            sb_cycle();
            n_total++;
            if (w_dec_valid !== 1'b1 || w_inst_pc !== exp_pc[k] || w_pc4 !== exp_pc[k] + 32'd4 ||
                w_inst !== (exp_pc[k] ^ XKEY))
                $display("FAIL wrap[%0d]: got valid=%b pc=%h pc4=%h inst=%h, expected pc=%h pc4=%h",
                         k, w_dec_valid, w_inst_pc, w_pc4, w_inst, exp_pc[k], exp_pc[k] + 32'd4);
            else n_pass++;
        end
    endtask

    task automatic test_async_reset();
        apply_reset();
        for (int i = 0; i < 3; i++) sb_cycle();
        #2 resetn = 1'b0;
        #1;
        n_total++;
        if (dec_valid !== 1'b0 || count !== 3'd0 || imem_addr !== 32'h0 || w_imem_addr !== WPC)
            $display("FAIL async_reset: got valid=%b count=%0d addr=%h waddr=%h, expected 0/0/0/%h",
                     dec_valid, count, imem_addr, w_imem_addr, WPC);
        else n_pass++;
        @(negedge clock);
        exp_q.delete();
        m_pc = 32'h0;
        resetn = 1'b1;
    endtask

    task automatic test_random();
        apply_reset();
        for (int i = 0; i < 300; i++) begin
            dec_ready = ($urandom_range(0, 3) != 0);
            pcsource  = ($urandom_range(0, 11) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            bpc = $urandom & 32'hFFFF_FFFC;
            rpc = $urandom & 32'hFFFF_FFFC;
            jpc = $urandom & 32'hFFFF_FFFC;
            sb_cycle();
        end
        pcsource = 2'b00;
    endtask

    initial begin
        n_pass = 0;
        n_total = 0;
        resetn = 1'b0;
        pcsource = 2'b00;
        bpc = '0;
        rpc = '0;
        jpc = '0;
        dec_ready = 1'b0;
        m_pc = '0;
        @(negedge clock);
        test_reset();
        test_stall();
        test_branch();
        test_back_to_back();
        test_wrap();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
